// File: rtl/avalon_cmd_fifo_pio_if.sv
// rtl/avalon_cmd_fifo_pio_if.sv - Avalon-MM register bus plus command stream bundle
// Ports (slave view): address[1:0], chipselect, write_n, writedata[31:0] in; readdata[31:0] out;
//   out_data[DATA_W-1:0], out_valid out; out_ready in; out_port[DATA_W-1:0], irq out.
interface avalon_cmd_fifo_pio_if #(
   parameter int DATA_W = 32
);
   logic [1:0]        address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_port;
   logic              irq;

   modport slave (
      input  address, chipselect, write_n, writedata, out_ready,
      output readdata, out_data, out_valid, out_port, irq
   );

   modport master (
      output address, chipselect, write_n, writedata, out_ready,
      input  readdata, out_data, out_valid, out_port, irq
   );
endinterface

// File: rtl/avalon_cmd_fifo_pio.sv
// rtl/avalon_cmd_fifo_pio.sv - Avalon-MM command FIFO with stream drain, legacy PIO and status flags
// Ports: clk, reset (sync, active-high); bus = avalon_cmd_fifo_pio_if.slave.
// Optional feature macro: CMD_FIFO_IRQ_EN (irq mask at addr3 and registered irq).
module avalon_cmd_fifo_pio #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   avalon_cmd_fifo_pio_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic [DATA_W-1:0] out_port_q, out_port_d;
   logic              overflow_q, overflow_d;
   logic              drained_q, drained_d;

   logic wr, push_req, ctl_wr, flush, empty, full, pop, push_ok;
   logic [31:0] rdata;
   logic [7:0]  status_cnt;

`ifdef CMD_FIFO_IRQ_EN
   logic [1:0] mask_q, mask_d;
   logic       irq_q, irq_d;
`endif

   always_comb begin
      wr       = bus.chipselect & ~bus.write_n;
      push_req = wr && (bus.address == 2'd0);
      ctl_wr   = wr && (bus.address == 2'd1);
      flush    = ctl_wr & bus.writedata[1];
      empty    = (count_q == '0);
      full     = (count_q == FULL_CNT);
      // Flush discards a concurrent pop so the head is neither consumed nor reported as drained.
      pop      = ~empty & bus.out_ready & ~flush;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
      push_ok  = push_req & (~full | pop);

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_ok) - CW'(pop);
      end

      shadow_d   = push_ok ? bus.writedata[DATA_W-1:0] : shadow_q;
      out_port_d = (wr && bus.address == 2'd2) ? bus.writedata[DATA_W-1:0] : out_port_q;

      // Sticky flags: set term is OR-ed after the clear so set wins.
      overflow_d = (overflow_q & ~(ctl_wr & bus.writedata[0])) | (push_req & full & ~pop);
      drained_d  = (drained_q & ~(ctl_wr & bus.writedata[2]))
                 | (pop & ~push_ok & (count_q == CW'(1)));

`ifdef CMD_FIFO_IRQ_EN
      mask_d = (wr && bus.address == 2'd3) ? bus.writedata[1:0] : mask_q;
      irq_d  = (overflow_q & mask_q[0]) | (drained_q & mask_q[1]);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         shadow_q   <= '0;
         out_port_q <= '0;
         overflow_q <= 1'b0;
         drained_q  <= 1'b0;
`ifdef CMD_FIFO_IRQ_EN
         mask_q     <= '0;
         irq_q      <= 1'b0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         shadow_q   <= shadow_d;
         out_port_q <= out_port_d;
         overflow_q <= overflow_d;
         drained_q  <= drained_d;
`ifdef CMD_FIFO_IRQ_EN
         mask_q     <= mask_d;
         irq_q      <= irq_d;
`endif
      end
   end

   // Storage is not reset; contents are only visible while count says they are valid.
   always_ff @(posedge clk) begin
      if (!reset && push_ok) mem_q[wr_ptr_q] <= bus.writedata[DATA_W-1:0];
   end

   always_comb begin
      status_cnt = 8'(count_q);
      rdata      = '0;
      case (bus.address)
         2'd0: rdata[DATA_W-1:0] = shadow_q;
         2'd1: rdata[11:0] = {drained_q, overflow_q, full, empty, status_cnt};
         2'd2: rdata[DATA_W-1:0] = out_port_q;
`ifdef CMD_FIFO_IRQ_EN
         2'd3: rdata[1:0] = mask_q;
`endif
         default: rdata = '0;
      endcase
   end

   assign bus.readdata  = rdata;
   assign bus.out_data  = mem_q[rd_ptr_q];
   assign bus.out_valid = ~empty;
   assign bus.out_port  = out_port_q;
`ifdef CMD_FIFO_IRQ_EN
   assign bus.irq       = irq_q;
`else
   assign bus.irq       = 1'b0;
`endif
endmodule

// File: tb/tb_avalon_cmd_fifo_pio.sv
// tb/tb_avalon_cmd_fifo_pio.sv - directed self-checking bench for avalon_cmd_fifo_pio
module tb_avalon_cmd_fifo_pio;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   avalon_cmd_fifo_pio_if #(.DATA_W(32)) bus ();

   avalon_cmd_fifo_pio #(.DATA_W(32), .DEPTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // All tasks start and end just after a negedge; inputs change there, outputs are sampled there.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      #1;
      d = bus.readdata;
      bus.chipselect = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h100) begin failures++; $display("FAIL reset_status got=%h exp=%h", rd, 32'h100); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
      // Reset mid-stream
      bus_write(2'd2, 32'h5A);
      for (int i = 0; i < 3; i++) bus_write(2'd0, 32'h40 + i);
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h3) begin failures++; $display("FAIL prereset_status got=%h exp=%h", rd, 32'h3); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h100) begin failures++; $display("FAIL midreset_status got=%h exp=%h", rd, 32'h100); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.out_port !== 32'h0) begin failures++; $display("FAIL midreset_out_port got=%h exp=0", bus.out_port); end
      bus_read(2'd0, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL midreset_shadow got=%h exp=0", rd); end
   endtask

   task automatic test_ordering();
      logic [31:0] rd;
      logic [31:0] exp_w [3];
      exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33;
      bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL order_pre_valid got=%b exp=0", bus.out_valid); end
      bus_write(2'd0, 32'h11);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11) begin
         failures++; $display("FAIL order_latency got=%b/%h exp=1/%h", bus.out_valid, bus.out_data, 32'h11); end
      bus_write(2'd0, 32'h22);
      bus_write(2'd0, 32'h33);
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h3) begin failures++; $display("FAIL order_count got=%h exp=%h", rd, 32'h3); end
      bus_read(2'd0, rd);
      checks++; if (rd !== 32'h33) begin failures++; $display("FAIL order_shadow got=%h exp=%h", rd, 32'h33); end
      checks++; if (bus.out_data !== 32'h11) begin failures++; $display("FAIL order_hold got=%h exp=%h", bus.out_data, 32'h11); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_w[i]) begin
            failures++; $display("FAIL order_drain%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.out_data, exp_w[i]); end
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h900) begin failures++; $display("FAIL order_drained_status got=%h exp=%h", rd, 32'h900); end
      bus_write(2'd1, 32'h4);
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h100) begin failures++; $display("FAIL order_clear_drained got=%h exp=%h", rd, 32'h100); end
   endtask

   task automatic test_overflow_full_pop();
      logic [31:0] rd;
      logic [31:0] exp_w;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h100 + i);
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h608) begin failures++; $display("FAIL ovf_status got=%h exp=%h", rd, 32'h608); end
      bus_read(2'd0, rd);
      checks++; if (rd !== 32'h107) begin failures++; $display("FAIL ovf_shadow got=%h exp=%h", rd, 32'h107); end
      bus_write(2'd1, 32'h1);
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h208) begin failures++; $display("FAIL ovf_clear got=%h exp=%h", rd, 32'h208); end
      checks++; if (bus.out_data !== 32'h100) begin failures++; $display("FAIL full_head got=%h exp=%h", bus.out_data, 32'h100); end
      // Push into a full FIFO while the consumer takes the head.
      bus.out_ready = 1'b1;
      bus_write(2'd0, 32'hABC);
      bus.out_ready = 1'b0;
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h208) begin failures++; $display("FAIL fullpp_status got=%h exp=%h", rd, 32'h208); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_w = (i < 7) ? (32'h101 + i) : 32'hABC;
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_w) begin
            failures++; $display("FAIL fullpp_drain%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.out_data, exp_w); end
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fullpp_empty got=%b exp=0", bus.out_valid); end
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h900) begin failures++; $display("FAIL fullpp_drained got=%h exp=%h", rd, 32'h900); end
      bus_write(2'd1, 32'h4);
   endtask

   task automatic test_flush_vs_pop();
      logic [31:0] rd;
      bus.out_ready = 1'b0;
      bus_write(2'd0, 32'h55);
      bus.out_ready = 1'b1;
      bus_write(2'd1, 32'h2);
      bus.out_ready = 1'b0;
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h100) begin failures++; $display("FAIL flush_pop_status got=%h exp=%h", rd, 32'h100); end
      for (int i = 0; i < 3; i++) bus_write(2'd0, 32'h60 + i);
      bus_write(2'd1, 32'h2);
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h100) begin failures++; $display("FAIL flush3_status got=%h exp=%h", rd, 32'h100); end
      bus_write(2'd0, 32'h77);
      checks++; if (bus.out_data !== 32'h77) begin failures++; $display("FAIL flush_ptr_reset got=%h exp=%h", bus.out_data, 32'h77); end
      bus_write(2'd1, 32'h2);
      bus_write(2'd2, 32'hA5);
      checks++; if (bus.out_port !== 32'hA5) begin failures++; $display("FAIL out_port got=%h exp=%h", bus.out_port, 32'hA5); end
      bus_read(2'd2, rd);
      checks++; if (rd !== 32'hA5) begin failures++; $display("FAIL out_port_read got=%h exp=%h", rd, 32'hA5); end
   endtask

   task automatic test_irq();
      logic [31:0] rd;
      bus.out_ready = 1'b0;
`ifdef CMD_FIFO_IRQ_EN
      bus_write(2'd3, 32'h1);
      bus_read(2'd3, rd);
      checks++; if (rd !== 32'h1) begin failures++; $display("FAIL irq_mask_read got=%h exp=1", rd); end
      for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h200 + i);
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", bus.irq); end
      @(negedge clk);
      checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", bus.irq); end
      bus_write(2'd1, 32'h1);
      @(negedge clk);
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", bus.irq); end
`else
      bus_write(2'd3, 32'hFF);
      bus_read(2'd3, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL addr3_read got=%h exp=0", rd); end
      for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h200 + i);
      bus_read(2'd1, rd);
      checks++; if (rd !== 32'h608) begin failures++; $display("FAIL irqoff_status got=%h exp=%h", rd, 32'h608); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_off%0d got=%b exp=0", i, bus.irq); end
         @(negedge clk);
      end
      bus_write(2'd1, 32'h1);
`endif
      bus_write(2'd1, 32'h2);
   endtask

   initial begin
      reset          = 1'b1;
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      bus.out_ready  = 1'b0;
      @(negedge clk);
      test_reset();
      test_ordering();
      test_overflow_full_pop();
      test_flush_vs_pop();
      test_irq();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
